// File: rtl/key_bounce_gen_if.sv
// Press-request / key-pin bundle between a stimulus controller and key_bounce_gen.
interface key_bounce_gen_if;
    logic Press_Req;
    logic Bounce_En;
    logic Pin_Out;
    logic Busy;
    logic Done;

    modport master (
        output Press_Req,
        output Bounce_En,
        input  Pin_Out,
        input  Busy,
        input  Done
    );

    modport slave (
        input  Press_Req,
        input  Bounce_En,
        output Pin_Out,
        output Busy,
        output Done
    );
endinterface

// File: rtl/key_bounce_gen.sv
// Emulated mechanical push-key: active-low pin with LFSR-timed bounce bursts on both edges.
// state   | meaning
// IDLE    | pin released (1), waiting for a press request
// PRESS_B | pin low with pseudo-random bounce toggles, BOUNCE_CYC cycles
// HOLD    | pin settled low, HOLD_CYC cycles
// REL_B   | pin high with pseudo-random bounce toggles, BOUNCE_CYC cycles
// DONE    | pin settled high, one-cycle completion pulse
module key_bounce_gen #(
    parameter int          BOUNCE_CYC     = 64,
    parameter int          HOLD_CYC       = 100,
    parameter int          BOUNCE_TOGGLES = 4,
    parameter logic [7:0]  GAP_MASK       = 8'h07,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RST_n,
    key_bounce_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESS_B = 3'd1,
        S_HOLD    = 3'd2,
        S_REL_B   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int CNT_MAX = (BOUNCE_CYC > HOLD_CYC) ? BOUNCE_CYC : HOLD_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int GW      = 9;
    localparam int TW      = $clog2(BOUNCE_TOGGLES + 2);

    localparam logic [CW-1:0] C_PHASE_LAST = CW'(BOUNCE_CYC - 1);
    localparam logic [CW-1:0] C_HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] C_TOG_MAX    = TW'(BOUNCE_TOGGLES);

    state_t          r_state;
    logic            r_pin;
    logic            r_busy;
    logic            r_done;
    logic [15:0]     r_lfsr;
    logic [CW-1:0]   r_cnt;
    logic [GW-1:0]   r_gap;
    logic [TW-1:0]   r_tog;
    logic            r_en;

    state_t          w_state_nxt;
    logic            w_pin_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [GW-1:0]   w_gap_nxt;
    logic [TW-1:0]   w_tog_nxt;
    logic            w_en_nxt;
    logic            w_fb;
    logic [15:0]     w_lfsr_nxt;
    logic [GW-1:0]   w_gap_load;
    logic [GW-1:0]   w_gap_dec;
    logic            w_gap_hit;
    logic            w_tog_ok;

    // Fibonacci LFSR, taps 16,14,13,11; free-running in every state
    assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_nxt = {r_lfsr[14:0], w_fb};

    assign w_gap_load = {1'b0, (r_lfsr[7:0] & GAP_MASK)} + 9'd1;
    assign w_gap_dec  = (r_gap != '0) ? (r_gap - 9'd1) : '0;
    assign w_gap_hit  = (r_gap == 9'd1);
    assign w_tog_ok   = r_en && (r_tog < C_TOG_MAX);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
            r_pin   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lfsr  <= LFSR_SEED;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_tog   <= '0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pin   <= w_pin_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_tog   <= w_tog_nxt;
            r_en    <= w_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pin_nxt   = r_pin;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_tog_nxt   = r_tog;
        w_en_nxt    = r_en;

        case (r_state)
            S_IDLE: begin
                w_pin_nxt = 1'b1;
                if (bus.Press_Req) begin
                    w_state_nxt = S_PRESS_B;
                    w_pin_nxt   = 1'b0;
                    w_en_nxt    = bus.Bounce_En;
                    w_cnt_nxt   = '0;
                    w_tog_nxt   = '0;
                    w_gap_nxt   = w_gap_load;
                end
            end

            S_PRESS_B, S_REL_B: begin
                w_cnt_nxt = r_cnt + 1'b1;
                w_gap_nxt = w_gap_dec;
                if (r_cnt == C_PHASE_LAST) begin
                    // phase boundary overrides any pending toggle and fixes the pin level
                    w_cnt_nxt = '0;
                    if (r_state == S_PRESS_B) begin
                        w_state_nxt = S_HOLD;
                        w_pin_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_pin_nxt   = 1'b1;
                    end
                end else if (w_gap_hit && w_tog_ok) begin
                    w_pin_nxt = ~r_pin;
                    w_tog_nxt = r_tog + 1'b1;
                    w_gap_nxt = w_gap_load;
                end
            end

            S_HOLD: begin
                w_pin_nxt = 1'b0;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_HOLD_LAST) begin
                    w_state_nxt = S_REL_B;
                    w_pin_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_tog_nxt   = '0;
                    w_gap_nxt   = w_gap_load;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_pin_nxt   = 1'b1;
                w_cnt_nxt   = '0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_pin_nxt   = 1'b1;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.Pin_Out = r_pin;
    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;

endmodule

// File: doc/key_bounce_gen.md
Name: key_bounce_gen

Overview:
Stimulus-side counterpart to the key debouncer: it emulates a mechanical push-key on a pin. On a single-cycle press request it drives an active-low key waveform. Each edge carries a bounded burst of pseudo-random bounce toggles, and a clean hold sits between press and release. Its output feeds the debounce chain's pin input for on-board self-test and virtual-key demos.

Parameters:
BOUNCE_CYC, 64, length in cycles of each bounce phase (press and release); >= 2.
HOLD_CYC, 100, cycles the key is held settled low between phases; >= 1.
BOUNCE_TOGGLES, 4, maximum toggle events per bounce phase; 0 = clean edges.
GAP_MASK, 8'h07, mask on LFSR[7:0]; the gap between toggles is 1 + (LFSR[7:0] & GAP_MASK) cycles.
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RST_n  input  1  asynchronous active-low reset.
Press_Req  input  1  single-cycle press request; accepted only in IDLE.
Bounce_En  input  1  1 = bounce toggles enabled; sampled when Press_Req is accepted.
Pin_Out  output  1  emulated key pin: idle 1, pressed 0.
Busy  output  1  1 in every state except IDLE.
Done  output  1  one-cycle pulse when the release has settled.

Behaviour:
- Reset (async, immediate): Pin_Out=1, Busy=0, Done=0, state=IDLE, LFSR=LFSR_SEED, all counters 0. Reset mid-operation forces Pin_Out=1 at once, with no completion pulse.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state; it never reaches 0.
- FSM: IDLE -> PRESS_B -> HOLD -> REL_B -> DONE -> IDLE.
- IDLE: Pin_Out=1. If Press_Req=1 at cycle k:
  - latch Bounce_En;
  - enter PRESS_B with Pin_Out=0 at k+1;
  - phase counter=0, toggle count=0;
  - gap counter loaded with 1+(LFSR[7:0]&GAP_MASK).
- PRESS_B: lasts exactly BOUNCE_CYC cycles (k+1 .. k+BOUNCE_CYC).
  - Each cycle the gap counter decrements.
  - When the gap counter reaches 0, latched Bounce_En=1, toggle count < BOUNCE_TOGGLES, and the phase has not ended:
    - Pin_Out inverts;
    - toggle count increments;
    - gap counter reloads from the current LFSR.
  - Toggles that do not fit inside BOUNCE_CYC are dropped.
- HOLD: entered at k+1+BOUNCE_CYC with Pin_Out forced to 0 regardless of toggle parity. Lasts HOLD_CYC cycles.
- REL_B: entered at k+1+BOUNCE_CYC+HOLD_CYC with Pin_Out=1. Toggle count and gap counter reinitialise. Same toggle rules as PRESS_B, for BOUNCE_CYC cycles.
- DONE: entered at k+1+2*BOUNCE_CYC+HOLD_CYC.
  - Pin_Out forced to 1, Done=1 for exactly this cycle, Busy=1.
  - Next cycle IDLE, Busy=0.
- Press_Req while Busy=1, including the DONE cycle, is ignored and not queued.
- Bounce_En changes after acceptance have no effect until the next accepted request.
- With Bounce_En=0 or BOUNCE_TOGGLES=0: exactly one falling edge and one rising edge per request.
- Counter widths are sized by $clog2 of their parameter and must not wrap within a phase.
- Pin_Out is a registered output with no glitches.

Test Plan:
- Reset, RST_n held low 5 cycles -> Pin_Out=1, Busy=0, Done=0; Pin_Out stays 1 for 200 idle cycles.
- Bounce_En=0, Press_Req at cycle 10 -> Pin_Out falls at 11 and rises at 175 with no other edges; Done=1 only at 239; Busy high 11..239.
- Bounce_En=1, Press_Req at 10 -> Pin_Out transitions within 11..74 <= 1+4, within 175..238 <= 1+4; Pin_Out=0 on all of 75..174; Pin_Out=1 at 239; toggle times match a reference LFSR model from seed 16'hACE1.
- Press_Req pulses at cycles 50, 120 and 239 during a busy cycle -> all ignored; exactly one Done pulse; a new Press_Req at 241 is accepted (Pin_Out=0 at 242).
- RST_n asserted at cycle 100 (inside HOLD) -> Pin_Out=1 within the same cycle with no clock needed; no Done pulse; after release, Press_Req gives the full sequence again.
- Loopback through the debouncer, Bounce_En=1 with production-scale BOUNCE_CYC -> exactly one clean press and one clean release observed at the debouncer output.
